// File: rtl/anita3_event_writer.sv
// anita3_event_writer: serialises one trigger record per handshake into the ping-pong event RAM.
// Define CHECKSUM_EN to append an XOR checksum word after the NUM_WORDS header words.
module anita3_event_writer #(
    parameter int unsigned NUM_WORDS = 8
) (
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        evt_valid_i,
    output logic        evt_ready_o,
    input  logic [31:0] evt_num_i,
    input  logic [31:0] evt_time_i,
    input  logic [15:0] evt_pps_i,
    input  logic [15:0] evt_pattern_i,
    input  logic [1:0]  buffer_active_i,
    output logic [7:0]  event_wr_addr_o,
    output logic [15:0] event_wr_dat_o,
    output logic        event_wr_o,
    output logic        event_done_o,
    output logic [1:0]  write_buffer_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

`ifdef CHECKSUM_EN
    localparam int unsigned LEN      = NUM_WORDS + 1;
    localparam logic [5:0]  CSUM_IDX = 6'(NUM_WORDS);
`else
    localparam int unsigned LEN      = NUM_WORDS;
`endif
    localparam logic [5:0]  LAST_IDX = 6'(LEN - 1);

    state_t      state_q, state_d;
    logic        wr_buf_q, wr_buf_d;
    logic [5:0]  word_idx_q, word_idx_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] num_q, num_d;
    logic [31:0] time_q, time_d;
    logic [15:0] pps_q, pps_d;
    logic [15:0] pat_q, pat_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] dat_q, dat_d;
`ifdef CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
`endif

    logic [5:0]  sel_idx;
    logic [15:0] sel_word;

    // Outputs are registered, so the word selected here is the one presented next cycle.
    assign sel_idx = (state_q == WRITE) ? word_idx_q + 6'd1 : 6'd0;

    always_comb begin
        sel_word = '0;
        case (sel_idx)
            6'd0:    sel_word = {8'hE0, 7'd0, wr_buf_q};
            6'd1:    sel_word = num_q[31:16];
            6'd2:    sel_word = num_q[15:0];
            6'd3:    sel_word = time_q[31:16];
            6'd4:    sel_word = time_q[15:0];
            6'd5:    sel_word = pps_q;
            6'd6:    sel_word = pat_q;
            6'd7:    sel_word = wait_cnt_q;
            default: sel_word = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_buf_d   = wr_buf_q;
        word_idx_d = word_idx_q;
        wait_cnt_d = wait_cnt_q;
        num_d      = num_q;
        time_d     = time_q;
        pps_d      = pps_q;
        pat_d      = pat_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        addr_d     = '0;
        dat_d      = '0;
`ifdef CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (evt_valid_i) begin
                    num_d      = evt_num_i;
                    time_d     = evt_time_i;
                    pps_d      = evt_pps_i;
                    pat_d      = evt_pattern_i;
                    wait_cnt_d = '0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (!buffer_active_i[wr_buf_q]) begin
                    state_d    = WRITE;
                    word_idx_d = '0;
                    wr_d       = 1'b1;
                    addr_d     = {1'b0, wr_buf_q, 6'd0};
                    dat_d      = sel_word;
`ifdef CHECKSUM_EN
                    csum_d     = sel_word;
`endif
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            WRITE: begin
                if (word_idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    addr_d  = {1'b0, wr_buf_q, 6'd0};
                end else begin
                    word_idx_d = sel_idx;
                    wr_d       = 1'b1;
                    addr_d     = {1'b0, wr_buf_q, sel_idx};
`ifdef CHECKSUM_EN
                    // csum_q already covers every word up to the one on the bus now.
                    if (sel_idx == CSUM_IDX) begin
                        dat_d = csum_q;
                    end else begin
                        dat_d  = sel_word;
                        csum_d = csum_q ^ sel_word;
                    end
`else
                    dat_d = sel_word;
`endif
                end
            end
            DONE: begin
                state_d  = IDLE;
                wr_buf_d = ~wr_buf_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            wr_buf_q   <= 1'b0;
            word_idx_q <= '0;
            wait_cnt_q <= '0;
            num_q      <= '0;
            time_q     <= '0;
            pps_q      <= '0;
            pat_q      <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            dat_q      <= '0;
`ifdef CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_buf_q   <= wr_buf_d;
            word_idx_q <= word_idx_d;
            wait_cnt_q <= wait_cnt_d;
            num_q      <= num_d;
            time_q     <= time_d;
            pps_q      <= pps_d;
            pat_q      <= pat_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
`ifdef CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign evt_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign write_buffer_o  = {1'b0, wr_buf_q};
    assign event_wr_o      = wr_q;
    assign event_done_o    = done_q;
    assign event_wr_addr_o = addr_q;
    assign event_wr_dat_o  = dat_q;

endmodule

// File: tb/tb_anita3_event_writer.sv
// Bench for anita3_event_writer: table of trigger records plus hand-written corner sequences,
// with expected RAM writes and done pulses queued at stimulus time and checked by a monitor.
module tb_anita3_event_writer;

    localparam int unsigned NW = 8;
`ifdef CHECKSUM_EN
    localparam int unsigned L = NW + 1;
`else
    localparam int unsigned L = NW;
`endif

    logic        clk33_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        evt_valid_i = 1'b0;
    logic        evt_ready_o;
    logic [31:0] evt_num_i = '0;
    logic [31:0] evt_time_i = '0;
    logic [15:0] evt_pps_i = '0;
    logic [15:0] evt_pattern_i = '0;
    logic [1:0]  buffer_active_i = '0;
    logic [7:0]  event_wr_addr_o;
    logic [15:0] event_wr_dat_o;
    logic        event_wr_o;
    logic        event_done_o;
    logic [1:0]  write_buffer_o;
    logic        busy_o;

    anita3_event_writer #(.NUM_WORDS(NW)) dut (
        .clk33_i(clk33_i), .rst_n_i(rst_n_i),
        .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
        .evt_num_i(evt_num_i), .evt_time_i(evt_time_i),
        .evt_pps_i(evt_pps_i), .evt_pattern_i(evt_pattern_i),
        .buffer_active_i(buffer_active_i),
        .event_wr_addr_o(event_wr_addr_o), .event_wr_dat_o(event_wr_dat_o),
        .event_wr_o(event_wr_o), .event_done_o(event_done_o),
        .write_buffer_o(write_buffer_o), .busy_o(busy_o)
    );

    always #15 clk33_i = ~clk33_i;

    int unsigned cyc = 0;
    always @(posedge clk33_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] num;
        logic [31:0] tim;
        logic [15:0] pps;
        logic [15:0] pat;
        int unsigned stall;
        logic        exp_buf;
        logic [15:0] exp_w0;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] dat;
        int unsigned cyc;
    } wr_t;

    wr_t wq[$];
    wr_t dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mword(input vec_t v, input logic [15:0] w, input int unsigned i);
        case (i)
            1: return v.num[31:16];
            2: return v.num[15:0];
            3: return v.tim[31:16];
            4: return v.tim[15:0];
            5: return v.pps;
            6: return v.pat;
            7: return w;
            default: return 16'h0000;
        endcase
    endfunction

    // Queue the writes and done pulse of one event whose handshake is sampled in cycle h.
    task automatic push_exp(input vec_t v, input logic b, input int unsigned h,
                            input int unsigned stall, input logic [15:0] w0);
        wr_t e;
`ifdef CHECKSUM_EN
        logic [15:0] x;
        x = '0;
`endif
        for (int unsigned i = 0; i < NW; i++) begin
            e.addr = {1'b0, b, 6'(i)};
            e.dat  = (i == 0) ? w0 : mword(v, 16'(stall), i);
            e.cyc  = h + 2 + stall + i;
`ifdef CHECKSUM_EN
            x ^= e.dat;
`endif
            wq.push_back(e);
        end
`ifdef CHECKSUM_EN
        e.addr = {1'b0, b, 6'(NW)};
        e.dat  = x;
        e.cyc  = h + 2 + stall + NW;
        wq.push_back(e);
`endif
        e.addr = {1'b0, b, 6'd0};
        e.dat  = '0;
        e.cyc  = h + 2 + L + stall;
        dq.push_back(e);
    endtask

    always @(negedge clk33_i) begin
        wr_t e;
        if (event_wr_o) begin
            if (wq.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
            else begin
                e = wq.pop_front();
                chk("wr_addr", {24'd0, event_wr_addr_o}, {24'd0, e.addr});
                chk("wr_dat", {16'd0, event_wr_dat_o}, {16'd0, e.dat});
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (event_done_o) begin
            if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = dq.pop_front();
                chk("done_addr", {24'd0, event_wr_addr_o}, {24'd0, e.addr});
                chk("done_cycle", cyc, e.cyc);
                chk("done_no_wr", {31'd0, event_wr_o}, 32'd0);
            end
        end
    end

    task automatic drive_rec(input vec_t v);
        evt_num_i     = v.num;
        evt_time_i    = v.tim;
        evt_pps_i     = v.pps;
        evt_pattern_i = v.pat;
    endtask

    task automatic drive_garbage();
        evt_num_i     = $urandom;
        evt_time_i    = $urandom;
        evt_pps_i     = 16'($urandom);
        evt_pattern_i = 16'($urandom);
    endtask

    task automatic wait_ready(input int unsigned exp_cyc);
        int unsigned n;
        n = 0;
        while (!evt_ready_o && n < 400) begin
            @(negedge clk33_i);
            n++;
        end
        chk("ready_cycle", cyc, exp_cyc);
        chk("busy_low", {31'd0, busy_o}, 32'd0);
        chk("wq_drained", wq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);
    endtask

    task automatic run_event(input vec_t v);
        int unsigned h;
        @(negedge clk33_i);
        drive_rec(v);
        evt_valid_i     = 1'b1;
        buffer_active_i = (v.stall != 0) ? (v.exp_buf ? 2'b10 : 2'b01) : 2'b00;
        chk("ready_idle", {31'd0, evt_ready_o}, 32'd1);
        chk("wbuf_before", {30'd0, write_buffer_o}, {31'd0, v.exp_buf});
        h = cyc;
        push_exp(v, v.exp_buf, h, v.stall, v.exp_w0);
        @(negedge clk33_i);
        evt_valid_i = 1'b0;
        drive_garbage();
        chk("ready_low", {31'd0, evt_ready_o}, 32'd0);
        chk("busy_high", {31'd0, busy_o}, 32'd1);
        repeat (v.stall) @(negedge clk33_i);
        buffer_active_i = 2'b00;
        wait_ready(h + 3 + L + v.stall);
        chk("wbuf_after", {30'd0, write_buffer_o}, {31'd0, ~v.exp_buf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        vec_t a, b, c;
        int unsigned h;

        tbl[0] = '{32'h12345678, 32'hDEADBEEF, 16'h0042, 16'h00A5, 0, 1'b0, 16'hE000};
        tbl[1] = '{32'hCAFEF00D, 32'h01020304, 16'h1111, 16'h5A5A, 0, 1'b1, 16'hE001};
        tbl[2] = '{32'h0BADF00D, 32'h55AA55AA, 16'h0003, 16'h0F0F, 5, 1'b0, 16'hE000};
        tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 16'hFFFF, 16'hFFFF, 1, 1'b1, 16'hE001};
        a = '{32'hA1A2A3A4, 32'hB1B2B3B4, 16'hC1C2, 16'hD1D2, 0, 1'b0, 16'hE000};
        b = '{32'h01234567, 32'h89ABCDEF, 16'h7777, 16'h8888, 0, 1'b1, 16'hE001};
        c = '{32'h00000001, 32'h00000002, 16'h0003, 16'h0004, 0, 1'b0, 16'hE000};

        #5;
        chk("rst_ready", {31'd0, evt_ready_o}, 32'd1);
        chk("rst_wr", {31'd0, event_wr_o}, 32'd0);
        chk("rst_done", {31'd0, event_done_o}, 32'd0);
        chk("rst_addr", {24'd0, event_wr_addr_o}, 32'd0);
        chk("rst_dat", {16'd0, event_wr_dat_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_wbuf", {30'd0, write_buffer_o}, 32'd0);
        repeat (2) @(negedge clk33_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 4; i++) run_event(tbl[i]);

        // valid held high across two back-to-back events
        @(negedge clk33_i);
        drive_rec(a);
        evt_valid_i = 1'b1;
        chk("hold_ready_a", {31'd0, evt_ready_o}, 32'd1);
        h = cyc;
        push_exp(a, 1'b0, h, 0, 16'hE000);
        @(negedge clk33_i);
        drive_garbage();
        chk("hold_ready_low", {31'd0, evt_ready_o}, 32'd0);
        while (cyc < h + 2 + L) @(negedge clk33_i);
        chk("hold_ready_done", {31'd0, evt_ready_o}, 32'd0);
        drive_rec(b);
        @(negedge clk33_i);
        chk("hold_ready_b", {31'd0, evt_ready_o}, 32'd1);
        push_exp(b, 1'b1, h + 3 + L, 0, 16'hE001);
        @(negedge clk33_i);
        evt_valid_i = 1'b0;
        drive_garbage();
        chk("hold_ready_low_b", {31'd0, evt_ready_o}, 32'd0);
        wait_ready(h + 6 + 2 * L);
        chk("hold_wbuf", {30'd0, write_buffer_o}, 32'd0);

        run_event(c);

        // reset while writing into buffer 1, after word 3
        @(negedge clk33_i);
        drive_rec(a);
        evt_valid_i = 1'b1;
        h = cyc;
        push_exp(a, 1'b1, h, 0, 16'hE001);
        @(negedge clk33_i);
        evt_valid_i = 1'b0;
        while (cyc < h + 5) @(negedge clk33_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        wq.delete();
        dq.delete();
        chk("mid_rst_wr", {31'd0, event_wr_o}, 32'd0);
        chk("mid_rst_addr", {24'd0, event_wr_addr_o}, 32'd0);
        chk("mid_rst_dat", {16'd0, event_wr_dat_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, evt_ready_o}, 32'd1);
        chk("mid_rst_wbuf", {30'd0, write_buffer_o}, 32'd0);
        repeat (3) @(negedge clk33_i);
        chk("mid_rst_done", {31'd0, event_done_o}, 32'd0);
        rst_n_i = 1'b1;
        run_event(c);

        repeat (5) @(negedge clk33_i);
        chk("final_wq", wq.size(), 32'd0);
        chk("final_dq", dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
